// File: rtl/string_packer_if.sv
// rtl/string_packer_if.sv - character-in / string-out handshake bundle for string_packer
//   in_vld/in_rdy/in_dat/in_lst : byte-wide character stream into the packer
//   out_vld/out_rdy             : completed-string handshake
//   out_str/out_len/out_ovf     : packed string, stored length, overflow flag
//   out_cnt                     : completed-string handshake counter
interface string_packer_if #(
  parameter int LEN = 16,
  parameter int CW  = 8
);
  localparam int LW = $clog2(LEN + 1);

  logic            in_vld;
  logic            in_rdy;
  logic [7:0]      in_dat;
  logic            in_lst;
  logic            out_vld;
  logic            out_rdy;
  logic [8*LEN-1:0] out_str;
  logic [LW-1:0]   out_len;
  logic            out_ovf;
  logic [CW-1:0]   out_cnt;

  // Character source and string consumer side.
  modport master (
    output in_vld, in_dat, in_lst, out_rdy,
    input  in_rdy, out_vld, out_str, out_len, out_ovf, out_cnt
  );

  // Packer side.
  modport slave (
    input  in_vld, in_dat, in_lst, out_rdy,
    output in_rdy, out_vld, out_str, out_len, out_ovf, out_cnt
  );
endinterface

// File: rtl/string_packer.sv
// rtl/string_packer.sv - packs a byte stream into a fixed-width string vector
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : string_packer_if.slave (character input stream, packed string output)
module string_packer #(
  parameter int         LEN     = 16,
  parameter logic [7:0] TERM    = 8'h00,
  parameter logic       TERM_NL = 1'b0,
  parameter int         CW      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  string_packer_if.slave bus
);
  localparam int LW = $clog2(LEN + 1);

  typedef enum logic [0:0] {COLLECT = 1'b0, DONE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [8*LEN-1:0] str_q, str_d;
  logic [LW-1:0]    len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             in_rdy_w;
  logic             in_hs;
  logic             out_hs;
  logic             is_term;
  logic [8*LEN-1:0] chr_ext;

  // Gated by rst_n so no character is taken while reset is asserted.
  assign in_rdy_w = (state_q == COLLECT) && rst_n;
  assign in_hs    = bus.in_vld && in_rdy_w;
  assign out_hs   = (state_q == DONE) && bus.out_rdy;
  assign is_term  = (bus.in_dat == TERM) || (TERM_NL && (bus.in_dat == 8'h0A));

  // Character widened to string width; shifting in at the low byte keeps the
  // most recent character in [7:0] with earlier ones moving up.
  always_comb begin
    chr_ext      = '0;
    chr_ext[7:0] = bus.in_dat;
  end

  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      COLLECT: begin
        if (in_hs) begin
          if (!is_term) begin
            if (len_q < LW'(LEN)) begin
              str_d = (str_q << 8) | chr_ext;
              len_d = len_q + LW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (is_term || bus.in_lst) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_hs) begin
          str_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = cnt_q + CW'(1);
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      str_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      str_q   <= str_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_rdy  = in_rdy_w;
  assign bus.out_vld = (state_q == DONE);
  assign bus.out_str = str_q;
  assign bus.out_len = len_q;
  assign bus.out_ovf = ovf_q;
  assign bus.out_cnt = cnt_q;
endmodule

// File: tb/tb_string_packer.sv
// tb/tb_string_packer.sv - directed-vector bench for string_packer
module tb_string_packer;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  string_packer_if #(.LEN(16), .CW(8)) if0 ();
  string_packer_if #(.LEN(16), .CW(2)) if1 ();

  string_packer #(.LEN(16), .TERM(8'h00), .TERM_NL(1'b0), .CW(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  string_packer #(.LEN(16), .TERM(8'h00), .TERM_NL(1'b1), .CW(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] c, input logic l);
    if (d == 0) begin
      if0.in_vld = v; if0.in_dat = c; if0.in_lst = l;
    end else begin
      if1.in_vld = v; if1.in_dat = c; if1.in_lst = l;
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? if0.in_rdy : if1.in_rdy;
  endfunction

  function automatic logic ovld(input int d);
    return (d == 0) ? if0.out_vld : if1.out_vld;
  endfunction

  // Called #1 after an edge; returns #1 after the handshake edge.
  task automatic send(input int d, input logic [7:0] c, input logic l);
    int t;
    t = 0;
    drive(d, 1'b1, c, l);
    while (!rdy(d) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) check("send_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    drive(d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_str(input int d, input string s, input logic lst_last);
    for (int i = 0; i < s.len(); i++)
      send(d, s[i], lst_last && (i == s.len() - 1));
  endtask

  task automatic pop(input int d);
    int t;
    t = 0;
    while (!ovld(d) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) check("pop_timeout", 128'd0, 128'd1);
    if (d == 0) if0.out_rdy = 1'b1; else if1.out_rdy = 1'b1;
    @(posedge clk); #1;
    if (d == 0) if0.out_rdy = 1'b0; else if1.out_rdy = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    if0.out_rdy = 1'b0;
    if1.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", 128'(if0.in_rdy), 128'd0);
    check("rst_out_vld", 128'(if0.out_vld), 128'd0);
    check("rst_str", 128'(if0.out_str), 128'd0);
    check("rst_len", 128'(if0.out_len), 128'd0);
    check("rst_ovf", 128'(if0.out_ovf), 128'd0);
    check("rst_cnt", 128'(if0.out_cnt), 128'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_rdy", 128'(if0.in_rdy), 128'd1);

    // Basic string
    send_str(0, "Hello world!", 1'b1);
    check("hello_vld", 128'(if0.out_vld), 128'd1);
    check("hello_len", 128'(if0.out_len), 128'd12);
    check("hello_str", 128'(if0.out_str), 128'h48656c6c6f20776f726c6421);
    check("hello_ovf", 128'(if0.out_ovf), 128'd0);
    pop(0);
    check("hello_cnt", 128'(if0.out_cnt), 128'd1);
    check("hello_vld_clr", 128'(if0.out_vld), 128'd0);
    check("hello_rdy_back", 128'(if0.in_rdy), 128'd1);
    check("hello_str_clr", 128'(if0.out_str), 128'd0);

    // Empty string, then "Finish." terminated by NUL
    send(0, 8'h00, 1'b0);
    check("empty_vld", 128'(if0.out_vld), 128'd1);
    check("empty_len", 128'(if0.out_len), 128'd0);
    check("empty_str", 128'(if0.out_str), 128'd0);
    pop(0);
    send_str(0, "Finish.", 1'b0);
    check("finish_pending", 128'(if0.out_vld), 128'd0);
    send(0, 8'h00, 1'b0);
    check("finish_len", 128'(if0.out_len), 128'd7);
    check("finish_str", 128'(if0.out_str), 128'h46696e6973682e);
    pop(0);
    check("finish_cnt", 128'(if0.out_cnt), 128'd3);

    // Overflow: 'A'..'T', in_lst on 'T'
    for (int i = 0; i < 20; i++) send(0, 8'h41 + 8'(i), i == 19);
    check("ovf_str", 128'(if0.out_str), 128'h4142434445464748494a4b4c4d4e4f50);
    check("ovf_len", 128'(if0.out_len), 128'd16);
    check("ovf_flag", 128'(if0.out_ovf), 128'd1);
    pop(0);
    check("ovf_clr", 128'(if0.out_ovf), 128'd0);

    // Backpressure: hold out_rdy low while poking in_vld
    send_str(0, "Hi", 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 8'h5A, 1'b1);
      @(posedge clk); #1;
      check("bp_in_rdy", 128'(if0.in_rdy), 128'd0);
      check("bp_out_vld", 128'(if0.out_vld), 128'd1);
      check("bp_str", 128'(if0.out_str), 128'h4869);
      check("bp_len", 128'(if0.out_len), 128'd2);
    end
    drive(0, 1'b0, 8'h00, 1'b0);
    pop(0);
    send_str(0, "Yo", 1'b1);
    check("yo_str", 128'(if0.out_str), 128'h596f);
    check("yo_len", 128'(if0.out_len), 128'd2);
    pop(0);
    check("yo_cnt", 128'(if0.out_cnt), 128'd6);

    // Newline termination on dut1; dut0 keeps collecting
    send_str(1, "ab\n", 1'b0);
    check("nl_vld", 128'(if1.out_vld), 128'd1);
    check("nl_len", 128'(if1.out_len), 128'd2);
    check("nl_str", 128'(if1.out_str), 128'h6162);
    pop(1);
    send_str(0, "ab\n", 1'b0);
    check("nonl_pending", 128'(if0.out_vld), 128'd0);
    check("nonl_len_pend", 128'(if0.out_len), 128'd3);
    send(0, 8'h00, 1'b0);
    check("nonl_len", 128'(if0.out_len), 128'd3);
    check("nonl_str", 128'(if0.out_str), 128'h61620a);
    pop(0);

    // Reset mid-string
    send_str(0, "abc", 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_in_rdy", 128'(if0.in_rdy), 128'd0);
    check("mid_rst_vld", 128'(if0.out_vld), 128'd0);
    check("mid_rst_len", 128'(if0.out_len), 128'd0);
    check("mid_rst_str", 128'(if0.out_str), 128'd0);
    check("mid_rst_cnt", 128'(if0.out_cnt), 128'd0);
    rst_n = 1'b1;
    #1;
    send(0, 8'h78, 1'b1);
    check("x_len", 128'(if0.out_len), 128'd1);
    check("x_str", 128'(if0.out_str), 128'h78);
    pop(0);
    check("x_cnt", 128'(if0.out_cnt), 128'd1);

    // Counter wrap on the CW=2 instance
    check("wrap_start", 128'(if1.out_cnt), 128'd0);
    for (int i = 0; i < 5; i++) begin
      send(1, 8'h6B, 1'b1);
      pop(1);
    end
    check("wrap_cnt", 128'(if1.out_cnt), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/string_packer.md
# string_packer

Synthesizable string assembler: accepts a byte-wide character stream over a valid/ready handshake and packs each message into a fixed-width vector. The packing follows the SystemVerilog string-to-packed layout: the last character lands in the low byte and unused upper bytes are zero, so waveform viewers can render the result as text. Each completed string is presented with its length and an overflow flag. It sits between character sources (UART RX, debug log ports) and consumers that expect whole messages, for example trace capture and waveform display.

## Interface
- `LEN`, 16: maximum characters stored per string (≥1).
- `TERM`, 8'h00: terminator character; ends the string and is not stored.
- `TERM_NL`, 1'b0: when 1, 8'h0A also terminates and is not stored.
- `CW`, 8: width of the completed-string counter.

Ports. Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `in_vld` input 1: input character valid.
- `in_rdy` output 1: block accepts a character.
- `in_dat` input 8: character.
- `in_lst` input 1: character is the last of the string.
- `out_vld` output 1: completed string available.
- `out_rdy` input 1: consumer accepts the string.
- `out_str` output 8*LEN: packed string; last char in [7:0], upper unused bytes zero.
- `out_len` output $clog2(LEN+1): number of stored characters (0..LEN).
- `out_ovf` output 1: more than LEN non-terminator characters were received.
- `out_cnt` output CW: count of completed-string handshakes; wraps modulo 2^CW.

## Operation
- States: COLLECT, DONE. Reset state is COLLECT.
- `in_rdy` = (state==COLLECT) && `rst_n`. `out_vld` = (state==DONE).
- Input handshake: `in_vld` && `in_rdy` at a rising edge.
- Accepted char c is a terminator when c==TERM, or when TERM_NL=1 and c==8'h0A.
- Accepted non-terminator, len<LEN: str <= {str[8*LEN-9:0], c}; len <= len+1.
- Accepted non-terminator, len==LEN: char dropped; ovf <= 1. The first LEN characters are kept.
- String ends on an accepted terminator, or on an accepted char with `in_lst`=1. A non-terminator carrying `in_lst` is stored or dropped per the rules above before the string ends. At the end, go to DONE.
- A terminator or `in_lst` with no stored characters yields an empty string: len 0, str all zero.
- DONE: `out_str`, `out_len` and `out_ovf` hold stable. No input is accepted.
- Output handshake (`out_vld` && `out_rdy`): str, len and ovf clear to 0; `out_cnt` increments; go to COLLECT.
- Width rule: len never exceeds LEN. `out_cnt` wraps from 2^CW-1 to 0.

## Timing
- Reset (`rst_n`=0 at an edge): state COLLECT, `out_str`=0, `out_len`=0, `out_ovf`=0, `out_cnt`=0, `out_vld`=0.
- While `rst_n`=0, `in_rdy`=0.
- Reset mid-string or in DONE discards the partial or pending string. `out_cnt` is not incremented.
- Latency: the string-ending input handshake at edge k gives `out_vld`=1 in the cycle after edge k.
- After the output handshake at edge m, `in_rdy`=1 in the cycle after edge m.
- Throughput: one string per (accepted chars + 1) cycles minimum.
- `in_rdy` does not depend combinationally on `in_vld`. `out_vld` does not depend combinationally on `out_rdy`.
- `out_vld`, once high, stays high with stable data until the handshake; this holds under any `out_rdy` pattern.
- Input ignored while `in_rdy`=0, regardless of `in_vld`.

## Test plan
- Basic string: LEN=16, stream "Hello world!" with `in_lst` on '!', `out_rdy`=1. Required: `out_len`=12, `out_str`={32'h0,"Hello world!"}, `out_ovf`=0, `out_cnt`=1.
- Empty string: first char 8'h00. Required: `out_len`=0, `out_str`=0, `out_vld` one cycle later. Then "Finish." terminated by 8'h00 gives `out_len`=7, `out_str` low 56 bits = "Finish.".
- Overflow: LEN=16, 20 chars 'A'..'T', then `in_lst` on 'T'. Required: `out_str`="ABCDEFGHIJKLMNOP", `out_len`=16, `out_ovf`=1.
- Backpressure: hold `out_rdy`=0 for 5 cycles after "Hi" completes. Required: `in_rdy`=0 throughout; `out_*` stable; `in_vld` pulses are ignored; after the handshake, the next "Yo" is packed alone (`out_str` low bytes 16'h596F).
- Newline mode: TERM_NL=1, stream "ab\n". Required: `out_len`=2, low bytes 16'h6162. With TERM_NL=0, the same stream gives a pending string of len 3.
- Reset mid-string: pulse `rst_n`=0 after "abc". Required: all outputs 0 and `in_rdy`=0 during reset; next "x" with `in_lst` gives `out_len`=1, `out_cnt`=1. Counter wrap: CW=2, 5 strings, `out_cnt`=1.
